// File: rtl/warp_issue_unit.sv
// Warp issue unit: fetches instruction words, decodes them and broadcasts one
// instruction per cycle to all functional-unit lanes. It then waits for the
// active lanes to complete and pulses done.
module warp_issue_unit #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned IMEM_AW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IMEM_AW-1:0]     base_pc,
    input  logic [5:0]             thread_count,
    output logic                   imem_rd_en,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [2:0]             type_instruction,
    output logic [4:0]             regnum_1,
    output logic [4:0]             regnum_2,
    output logic [4:0]             dest_reg,
    output logic [5:0]             shammt,
    output logic [NUM_THREADS-1:0] is_active,
    input  logic [NUM_THREADS-1:0] thread_complete,
    output logic                   busy,
    output logic                   done,
    output logic                   pc_overflow
);

    localparam logic [2:0]         OP_HALT = 3'b111;
    localparam logic [IMEM_AW-1:0] PC_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [IMEM_AW-1:0]   pc;           // next address to fetch
    logic                 fetch_valid;  // imem_rdata holds a word to decode this cycle
    logic                 fetch_end;    // last address already fetched; pc must not wrap
    logic [5:0]           count_clamped;
    logic [NUM_THREADS-1:0] start_mask;

    // Low byte of each instruction word carries no decoded field.
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata[7:0];

    // Clamp the requested thread count and build the lane-enable mask.
    always_comb begin
        count_clamped = thread_count;
        if (thread_count > 6'(NUM_THREADS)) begin
            count_clamped = 6'(NUM_THREADS);
        end
        start_mask = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            start_mask[i] = (6'(i) < count_clamped);
        end
    end

    // Sequencer FSM with all outputs registered; decoded fields fall back to NOP
    // every cycle unless a fetched word is issued on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= '0;
            fetch_valid      <= 1'b0;
            fetch_end        <= 1'b0;
            imem_rd_en       <= 1'b0;
            imem_addr        <= '0;
            type_instruction <= OP_HALT;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            is_active        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pc_overflow      <= 1'b0;
        end else begin
            type_instruction <= OP_HALT;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            imem_rd_en       <= 1'b0;
            imem_addr        <= '0;
            fetch_valid      <= 1'b0;
            done             <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pc_overflow <= 1'b0;
                        if (count_clamped == 6'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // First fetch goes out on the start edge itself.
                            state      <= RUN;
                            busy       <= 1'b1;
                            is_active  <= start_mask;
                            imem_rd_en <= 1'b1;
                            imem_addr  <= base_pc;
                            pc         <= base_pc + 1'b1;
                            fetch_end  <= (base_pc == PC_MAX);
                        end
                    end
                end

                RUN: begin
                    if (fetch_valid && imem_rdata[31:29] == OP_HALT) begin
                        // Issue HALT; the word still in flight is dropped.
                        type_instruction <= imem_rdata[31:29];
                        regnum_1         <= imem_rdata[28:24];
                        regnum_2         <= imem_rdata[23:19];
                        dest_reg         <= imem_rdata[18:14];
                        shammt           <= imem_rdata[13:8];
                        state            <= DRAIN;
                    end else if (!fetch_valid && !imem_rd_en && fetch_end) begin
                        // Ran off the top of memory without a HALT: forced NOP/HALT.
                        pc_overflow <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        if (fetch_valid) begin
                            type_instruction <= imem_rdata[31:29];
                            regnum_1         <= imem_rdata[28:24];
                            regnum_2         <= imem_rdata[23:19];
                            dest_reg         <= imem_rdata[18:14];
                            shammt           <= imem_rdata[13:8];
                        end
                        fetch_valid <= imem_rd_en;
                        if (!fetch_end) begin
                            imem_rd_en <= 1'b1;
                            imem_addr  <= pc;
                            pc         <= pc + 1'b1;
                            fetch_end  <= (pc == PC_MAX);
                        end
                    end
                end

                DRAIN: begin
                    if ((thread_complete & is_active) == is_active) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        is_active <= '0;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    fetch_end <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_warp_issue_unit.sv
// Bench for warp_issue_unit: per-cycle expected output vectors are queued when
// a launch is driven and compared at each negedge.
module tb_warp_issue_unit;

    localparam int NT = 4;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_pc;
    logic [5:0]    thread_count;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [2:0]    type_instruction;
    logic [4:0]    regnum_1;
    logic [4:0]    regnum_2;
    logic [4:0]    dest_reg;
    logic [5:0]    shammt;
    logic [NT-1:0] is_active;
    logic [NT-1:0] thread_complete;
    logic          busy;
    logic          done;
    logic          pc_overflow;

    warp_issue_unit #(.NUM_THREADS(NT), .IMEM_AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_pc          (base_pc),
        .thread_count     (thread_count),
        .imem_rd_en       (imem_rd_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .type_instruction (type_instruction),
        .regnum_1         (regnum_1),
        .regnum_2         (regnum_2),
        .dest_reg         (dest_reg),
        .shammt           (shammt),
        .is_active        (is_active),
        .thread_complete  (thread_complete),
        .busy             (busy),
        .done             (done),
        .pc_overflow      (pc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read strobe.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic [35:0] exp;
        logic [3:0]  tc;
        logic        st;
    } ent_t;

    ent_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prog [4];
    logic [23:0] nop_dec;

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {rd_en, addr, type, rs1, rs2, rd, shammt, busy, done, is_active, pc_overflow}
    function automatic logic [35:0] obs();
        return {imem_rd_en, imem_addr, type_instruction, regnum_1, regnum_2, dest_reg,
                shammt, busy, done, is_active, pc_overflow};
    endfunction

    task automatic push(input logic en, input logic [3:0] a, input logic [23:0] dec,
                        input logic bsy, input logic dn, input logic [3:0] act,
                        input logic ov, input logic [3:0] tc, input logic st);
        ent_t e;
        e.exp = {en, a, dec, bsy, dn, act, ov};
        e.tc  = tc;
        e.st  = st;
        sbq.push_back(e);
    endtask

    task automatic launch(input logic [AW-1:0] base, input logic [5:0] cnt);
        @(negedge clk);
        base_pc      = base;
        thread_count = cnt;
        start        = 1'b1;
    endtask

    task automatic run_trace(input string tag);
        int k = 0;
        while (sbq.size() > 0) begin
            ent_t e;
            @(negedge clk);
            e = sbq.pop_front();
            check_val($sformatf("%s[%0d]", tag, k), obs(), e.exp);
            thread_complete = e.tc;
            start           = e.st;
            k++;
        end
    endtask

    // Expected trace of the base_pc=8 program; extra adds DRAIN cycles while
    // a lane is late, poke drives start during DRAIN and DONE.
    task automatic push_prog(input logic [3:0] act, input logic [3:0] tc0, input int extra,
                             input logic poke);
        push(1, 4'd8,  nop_dec,        1, 0, act, 0, tc0, 0);
        push(1, 4'd9,  nop_dec,        1, 0, act, 0, tc0, 0);
        push(1, 4'd10, prog[0][31:8],  1, 0, act, 0, tc0, 0);
        push(1, 4'd11, prog[1][31:8],  1, 0, act, 0, tc0, 0);
        push(1, 4'd12, prog[2][31:8],  1, 0, act, 0, tc0, 0);
        push(0, 4'd0,  prog[3][31:8],  1, 0, act, 0, tc0, 0);
        for (int i = 0; i < extra; i++) begin
            push(0, 4'd0, nop_dec, 1, 0, act, 0, (i == extra - 1) ? 4'hF : tc0,
                 poke && (i == 0));
        end
        push(0, 4'd0, nop_dec, 0, 1, 4'h0, 0, 4'hF, poke);
        push(0, 4'd0, nop_dec, 0, 0, 4'h0, 0, 4'hF, 0);
        push(0, 4'd0, nop_dec, 0, 0, 4'h0, 0, 4'hF, 0);
    endtask

    initial begin
        nop_dec = {3'b111, 21'd0};
        for (int i = 0; i < 16; i++) begin
            mem[i] = {3'(i % 7), 5'(i), 5'(i + 3), 5'(i + 5), 6'(i * 3), 8'hC3};
        end
        prog[0] = {3'd0, 5'd1, 5'd2, 5'd3, 6'd0,  8'hA5};
        prog[1] = {3'd1, 5'd4, 5'd5, 5'd6, 6'd7,  8'h00};
        prog[2] = {3'd6, 5'd7, 5'd8, 5'd9, 6'd33, 8'hFF};
        prog[3] = {3'd7, 29'd0};
        for (int i = 0; i < 4; i++) mem[8 + i] = prog[i];
        mem[12] = {3'd3, 5'd31, 5'd30, 5'd29, 6'd63, 8'h11};

        rst = 1'b1;
        start = 1'b0;
        base_pc = '0;
        thread_count = '0;
        thread_complete = '0;
        repeat (3) @(negedge clk);
        check_val("reset", obs(), {1'b0, 4'd0, nop_dec, 1'b0, 1'b0, 4'h0, 1'b0});
        rst = 1'b0;

        // Normal program, all lanes complete.
        thread_complete = 4'hF;
        launch(4'd8, 6'd4);
        push_prog(4'hF, 4'hF, 0, 0);
        run_trace("halt_run");

        // Lane 2 late by 5 cycles; starts during DRAIN/DONE are ignored.
        thread_complete = 4'b1011;
        launch(4'd8, 6'd4);
        push_prog(4'hF, 4'b1011, 5, 1);
        run_trace("slow_lane");

        // Zero threads: straight to done, no fetch.
        launch(4'd8, 6'd0);
        push(0, 4'd0, nop_dec, 0, 1, 4'h0, 0, 4'hF, 0);
        push(0, 4'd0, nop_dec, 0, 0, 4'h0, 0, 4'hF, 0);
        push(0, 4'd0, nop_dec, 0, 0, 4'h0, 0, 4'hF, 0);
        run_trace("zero_cnt");

        // Count above NUM_THREADS clamps.
        launch(4'd8, 6'd9);
        push_prog(4'hF, 4'hF, 0, 0);
        run_trace("clamp");

        // Two lanes: upper lanes never complete but are masked off.
        thread_complete = 4'b0011;
        launch(4'd8, 6'd2);
        push_prog(4'b0011, 4'b0011, 0, 0);
        run_trace("two_lane");

        // Fetch reaches the top address with no HALT.
        thread_complete = 4'hF;
        launch(4'd14, 6'd4);
        push(1, 4'd14, nop_dec,        1, 0, 4'hF, 0, 4'hF, 0);
        push(1, 4'd15, nop_dec,        1, 0, 4'hF, 0, 4'hF, 0);
        push(0, 4'd0,  mem[14][31:8],  1, 0, 4'hF, 0, 4'hF, 0);
        push(0, 4'd0,  mem[15][31:8],  1, 0, 4'hF, 0, 4'hF, 0);
        push(0, 4'd0,  nop_dec,        1, 0, 4'hF, 1, 4'hF, 0);
        push(0, 4'd0,  nop_dec,        0, 1, 4'h0, 1, 4'hF, 0);
        for (int i = 0; i < 3; i++) push(0, 4'd0, nop_dec, 0, 0, 4'h0, 1, 4'hF, 0);
        run_trace("pc_wrap");

        // Reset while the third instruction is on the outputs; overflow cleared by start.
        launch(4'd8, 6'd4);
        push(1, 4'd8,  nop_dec,       1, 0, 4'hF, 0, 4'hF, 0);
        push(1, 4'd9,  nop_dec,       1, 0, 4'hF, 0, 4'hF, 0);
        push(1, 4'd10, prog[0][31:8], 1, 0, 4'hF, 0, 4'hF, 0);
        push(1, 4'd11, prog[1][31:8], 1, 0, 4'hF, 0, 4'hF, 0);
        push(1, 4'd12, prog[2][31:8], 1, 0, 4'hF, 0, 4'hF, 0);
        run_trace("pre_rst");
        #1 rst = 1'b1;
        #1 check_val("rst_async", obs(), {1'b0, 4'd0, nop_dec, 1'b0, 1'b0, 4'h0, 1'b0});
        @(negedge clk);
        check_val("rst_held", obs(), {1'b0, 4'd0, nop_dec, 1'b0, 1'b0, 4'h0, 1'b0});
        rst = 1'b0;
        launch(4'd8, 6'd4);
        push_prog(4'hF, 4'hF, 0, 0);
        run_trace("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
